// File: rtl/dmem_sized_if.sv
// Purpose : request/response bundle between the MEM stage and the sized data memory.
// Latency : n/a (wiring only); responses follow an accepted request by one cycle.
// Backpr. : busy=1 means requests are dropped; the requester holds off until busy=0.
// Ports   : master drives req/we/size/uns/addr/wdata; slave drives rdata/rvalid/err/busy.
interface dmem_sized_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              err;
    logic              busy;

    modport master (
        output req, we, size, uns, addr, wdata,
        input  rdata, rvalid, err, busy
    );

    modport slave (
        input  req, we, size, uns, addr, wdata,
        output rdata, rvalid, err, busy
    );
endinterface

// File: rtl/dmem_sized.sv
// Purpose : byte-addressed data memory with byte/half/word access, lane-masked stores,
//           sign/zero-extended loads, misalign/range checking and an optional zero-fill sweep.
// Latency : one cycle from accepted request to rvalid/err/rdata; stores land at the accepting edge.
// Backpr. : busy is high during the clear sweep; requests seen while busy are dropped silently.
// Ports   : clk, rst (sync, active-high), bus (slave side of dmem_sized_if).
module dmem_sized #(
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 32,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    dmem_sized_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic               busy;

    logic [31:0]        mem [DEPTH];

    logic [IDX_W-1:0]   idx;
    logic [1:0]         lane;
    logic               oor;
    logic               misal;
    logic               bad;
    logic               accept;
    logic               do_st;
    logic               do_ld;

    logic [3:0]         be;
    logic [31:0]        wword;
    logic [31:0]        rword;
    logic [7:0]         bsel;
    logic [15:0]        hsel;
    logic [31:0]        ld_val;

    logic [31:0]        rdata_q;
    logic               rvalid_q;
    logic               err_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (cnt == IDX_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            ST_IDLE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == ST_CLEAR);
    end

    // Sweep pointer; it restarts at word 0 on every reset, including mid-sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- address decode ----------------
    assign idx  = bus.addr[IDX_W+1:2];
    assign lane = bus.addr[1:0];

    // Any address bit above the word index means the access falls outside the array;
    // without this check high addresses would alias onto low words.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_oor
            assign oor = |bus.addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    always_comb begin
        misal = 1'b0;
        case (bus.size)
            SZ_B:    misal = 1'b0;
            SZ_H:    misal = lane[0];
            SZ_W:    misal = (lane != 2'b00);
            default: misal = 1'b1;
        endcase
    end

    assign bad    = misal | oor;
    assign accept = bus.req & ~busy;
    assign do_st  = accept & bus.we & ~bad;
    assign do_ld  = accept & ~bus.we & ~bad;

    // ---------------- store lane mask / data ----------------
    // Store data is right-justified, so it is replicated across lanes and the
    // byte enables pick which copy lands.
    always_comb begin
        be    = 4'b0000;
        wword = 32'h0;
        case (bus.size)
            SZ_B: begin
                be    = 4'b0001 << lane;
                wword = {4{bus.wdata[7:0]}};
            end
            SZ_H: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{bus.wdata[15:0]}};
            end
            SZ_W: begin
                be    = 4'b1111;
                wword = bus.wdata;
            end
            default: begin
                be    = 4'b0000;
                wword = 32'h0;
            end
        endcase
    end

    // Array has no reset: with CLR_ON_RST=0 contents survive reset, otherwise the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= 32'h0;
            end else if (do_st) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    // ---------------- load extraction ----------------
    assign rword = mem[idx];
    assign bsel  = rword[{lane, 3'b000} +: 8];
    assign hsel  = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ld_val = 32'h0;
        case (bus.size)
            SZ_B:    ld_val = bus.uns ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
            SZ_H:    ld_val = bus.uns ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
            SZ_W:    ld_val = rword;
            default: ld_val = 32'h0;
        endcase
    end

    // ---------------- response register ----------------
    // Stores and rejected accesses both return zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= accept;
            err_q    <= accept & bad;
            rdata_q  <= do_ld ? ld_val : 32'h0;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy;
endmodule

// File: tb/tb_dmem_sized.sv
// Purpose : self-checking bench for dmem_sized (DEPTH=64, CLR_ON_RST=1) using a response scoreboard.
// Latency : expects each accepted request to answer on the following cycle, in order.
// Backpr. : stimulus waits (bounded) for busy=0 before issuing requests.
module tb_dmem_sized;
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SX = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_sized_if #(.ADDR_W(32)) bus ();

    dmem_sized #(
        .DEPTH      (64),
        .ADDR_W     (32),
        .CLR_ON_RST (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    logic [32:0] exp_q[$];   // {err, rdata}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        string       t;
        logic [32:0] e;
        if (bus.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_rvalid", 32'd1, 32'd0);
            end else begin
                t = tag_q.pop_front();
                e = exp_q.pop_front();
                check({t, "_err"}, {31'h0, bus.err}, {31'h0, e[32]});
                check({t, "_rdata"}, bus.rdata, e[31:0]);
            end
        end
    end

    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_dat);
        int n;
        @(negedge clk);
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            bus.req = 1'b0;
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            check({tag, "_busy_timeout"}, 32'd1, 32'd0);
            bus.req = 1'b0;
            return;
        end
        bus.req   = 1'b1;
        bus.we    = w;
        bus.size  = sz;
        bus.uns   = u;
        bus.addr  = a;
        bus.wdata = wd;
        tag_q.push_back(tag);
        exp_q.push_back({e_err, e_dat});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    // Called at the negedge where rst has just been released; counts busy samples.
    task automatic measure_sweep(output int cycles, output int rv_seen);
        cycles  = 0;
        rv_seen = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            if (bus.rvalid !== 1'b0) rv_seen++;
            cycles++;
            @(negedge clk);
        end
        bus.req = 1'b0;
    endtask

    initial begin
        int cyc;
        int rv;
        int drop;

        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.size  = SW;
        bus.uns   = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;

        // Two-cycle reset with a load request held high throughout the sweep.
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 1'b1;
        @(negedge clk);
        check("rst_rdata",  bus.rdata, 32'h0);
        check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
        check("rst_err",    {31'h0, bus.err}, 32'h0);
        check("rst_busy",   {31'h0, bus.busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        measure_sweep(cyc, rv);
        check("sweep_len",    cyc, 32'd64);
        check("sweep_rvalid", rv,  32'd0);

        // Cleared array, word loads at both ends.
        access("ldW00",  1'b0, SW, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);
        access("ldWFC",  1'b0, SW, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0);

        // Word store then extended sub-word loads, issued back-to-back.
        access("stW10",  1'b1, SW, 1'b0, 32'h10, 32'h8899AABB, 1'b0, 32'h0);
        access("ldB13s", 1'b0, SB, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFF88);
        access("ldB13u", 1'b0, SB, 1'b1, 32'h13, 32'h0, 1'b0, 32'h00000088);
        access("ldH10s", 1'b0, SH, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFAABB);
        access("ldH12u", 1'b0, SH, 1'b1, 32'h12, 32'h0, 1'b0, 32'h00008899);
        access("ldB10s", 1'b0, SB, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFBB);
        access("ldB11u", 1'b0, SB, 1'b1, 32'h11, 32'h0, 1'b0, 32'h000000AA);
        access("ldW10",  1'b0, SW, 1'b1, 32'h10, 32'h0, 1'b0, 32'h8899AABB);
        idle(2);

        // Byte and half stores leave the other lanes alone.
        access("stW10z", 1'b1, SW, 1'b0, 32'h10, 32'h00000000, 1'b0, 32'h0);
        access("stB11",  1'b1, SB, 1'b0, 32'h11, 32'hFFFFFF5A, 1'b0, 32'h0);
        access("ldW10b", 1'b0, SW, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00005A00);
        access("stH16",  1'b1, SH, 1'b0, 32'h16, 32'hABCD1234, 1'b0, 32'h0);
        access("ldW14",  1'b0, SW, 1'b0, 32'h14, 32'h0, 1'b0, 32'h12340000);
        access("ldH16s", 1'b0, SH, 1'b0, 32'h16, 32'h0, 1'b0, 32'h00001234);
        idle(1);

        // Misaligned / illegal-size accesses are rejected and write nothing.
        access("ldH03",  1'b0, SH, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0);
        access("ldW02",  1'b0, SW, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0);
        access("ldS3",   1'b0, SX, 1'b0, 32'h00, 32'h0, 1'b1, 32'h0);
        access("stW02",  1'b1, SW, 1'b0, 32'h02, 32'hDEADBEEF, 1'b1, 32'h0);
        access("stH01",  1'b1, SH, 1'b0, 32'h01, 32'h0000BEEF, 1'b1, 32'h0);
        access("stS3",   1'b1, SX, 1'b0, 32'h00, 32'hDEADBEEF, 1'b1, 32'h0);
        access("ldW00b", 1'b0, SW, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);
        idle(1);

        // Out-of-range accesses are rejected and do not alias onto low words.
        access("stW100", 1'b1, SW, 1'b0, 32'h100, 32'hCAFEF00D, 1'b1, 32'h0);
        access("ldW100", 1'b0, SW, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0);
        access("ldWhi",  1'b0, SW, 1'b0, 32'h80000000, 32'h0, 1'b1, 32'h0);
        access("ldW00c", 1'b0, SW, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0);
        access("stWFC",  1'b1, SW, 1'b0, 32'hFC, 32'h01020304, 1'b0, 32'h0);
        access("ldBFFu", 1'b0, SB, 1'b1, 32'hFF, 32'h0, 1'b0, 32'h00000001);

        // Data that a reset-restarted sweep must wipe.
        access("stW40",  1'b1, SW, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'h0);
        access("ldW40",  1'b0, SW, 1'b0, 32'h40, 32'h0, 1'b0, 32'h12345678);
        idle(2);

        // Reset, then reset again 30 cycles into the sweep.
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        drop = 0;
        repeat (30) begin
            if (bus.busy !== 1'b1) drop++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        if (bus.busy !== 1'b1) drop++;
        rst = 1'b0;
        measure_sweep(cyc, rv);
        check("sweep2_len",    cyc,  32'd64);
        check("sweep2_rvalid", rv,   32'd0);
        check("sweep2_cont",   drop, 32'd0);

        access("ldW40z", 1'b0, SW, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        access("ldW10z", 1'b0, SW, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        access("ldWFCz", 1'b0, SW, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h0);
        idle(4);

        check("drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised successor to the single-port data memory; sits between the MIPS datapath's MEM stage and the load/store unit.
- Byte-addressed, with byte, halfword and word access sizes. Loads can be sign- or zero-extended.
- Writes are byte-lane masked. Reads have one registered cycle of latency with a valid strobe.
- Detects misaligned and out-of-range accesses, and can zero the whole array after reset with a hardware clear sweep.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, at least 4.
- ADDR_W, 32, width of the byte address input.
- CLR_ON_RST, 1, 1 = run the zero-fill sweep after reset; 0 = keep array contents across reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset.
- req  input  1  access request, sampled when busy=0.
- we  input  1  1 = store, 0 = load; qualified by req.
- size  input  2  00 byte, 01 half, 10 word; 11 is illegal and reported as misaligned.
- uns  input  1  load extension: 1 = zero-extend, 0 = sign-extend; ignored for word loads and stores.
- addr  input  ADDR_W  byte address.
- wdata  input  32  store data, right-justified: byte in [7:0], half in [15:0].
- rdata  output  32  load result, extended to 32 bits.
- rvalid  output  1  one-cycle pulse one cycle after any accepted request (load or store).
- err  output  1  accompanies rvalid; 1 = access rejected.
- busy  output  1  clear sweep in progress; requests are ignored while high.

Behaviour:
- Reset is synchronous and active-high on clk; one clock, no other clock domains.
- Reset values:
  - rdata=0, rvalid=0, err=0.
  - busy=1 if CLR_ON_RST, otherwise 0.
  - FSM enters CLEAR if CLR_ON_RST, otherwise IDLE.
  - Clear counter = 0.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to word[cnt], then cnt++.
  - CLEAR → IDLE in the cycle after word DEPTH-1 is written. busy therefore stays high for exactly DEPTH cycles after rst deasserts.
  - Reset asserted mid-sweep restarts the sweep at word 0.
- Decode:
  - word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
  - Out of range if any addr bit above log2(DEPTH)+1 is set (ignored when ADDR_W is too narrow to hold such bits).
  - Misaligned if size=01 with addr[0]=1, size=10 with addr[1:0]≠0, or size=11.
- Accept: req=1 and busy=0.
  - In the following cycle rvalid=1, and err=1 if the access was misaligned or out of range.
  - A rejected access writes nothing and returns rdata=0.
- Store (accepted, legal):
  - Array is updated at the accepting edge.
  - Byte: lane L gets wdata[7:0].
  - Half: lanes {addr[1],1} and {addr[1],0} get wdata[15:0].
  - Word: all four lanes.
  - Unselected lanes are unchanged.
  - rdata for a store is 0.
- Load (accepted, legal):
  - rdata is the selected field, extended per uns, registered at the accepting edge. Latency is 1 cycle.
  - Byte lanes are little-endian: lane 0 = bits [7:0].
- Back-to-back accesses: a load issued the cycle after a store to the same word returns the updated data. There is no stale read.
- rvalid is held low whenever no request was accepted on the prior edge, and during CLEAR.
- Any req during busy is dropped with no response. The requester must wait for busy=0.
- With CLR_ON_RST=0: no sweep, array contents are undefined at power-up, and reset leaves the array untouched.

Test Plan:
- CLR_ON_RST=1, DEPTH=64: pulse rst for 2 cycles, then hold req=1 → busy high for exactly 64 cycles and no rvalid; then word loads of addr 0x0 and 0xFC return 0 with err=0.
- Word store 0x8899AABB at 0x10, then byte load at 0x13 with uns=0 → 0xFFFFFF88; with uns=1 → 0x00000088; half load at 0x10 with uns=0 → 0xFFFFAABB.
- Byte store 0x5A at 0x11 over word 0x00000000, then word load at 0x10 → 0x00005A00 (other lanes untouched).
- Half load at 0x03, word load at 0x02, size=11 at 0x00 → each gives rvalid=1, err=1, rdata=0; a following word load at 0x00 shows memory unchanged.
- Word store at 0x100 with DEPTH=64 (out of range) → err=1; a word load at 0x000 is unaffected (no aliasing).
- Assert rst at sweep cycle 30 → busy is continuous and deasserts 64 cycles after that rst; a word previously holding 0x12345678 reads 0.
